peripheral_bus: RTL and testbench

//   Memory-mapped peripheral slave on the CPU data bus, alongside the data memory. Decodes

---
 rtl/peripheral_bus.sv | 165 ++++++++++++++++
 tb/tb_peripheral_bus.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_bus.sv
// Memory-mapped peripheral slave: timer with interrupt, LED/7-segment outputs,
// synchronised switch input and a free-running tick counter in a 32-byte window.
module peripheral_bus #(
  parameter logic [31:0] BASE     = 32'h4000_0000,
  parameter int          PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irqout
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  localparam logic [2:0] OFF_TH   = 3'd0;
  localparam logic [2:0] OFF_TL   = 3'd1;
  localparam logic [2:0] OFF_TCON = 3'd2;
  localparam logic [2:0] OFF_LED  = 3'd3;
  localparam logic [2:0] OFF_SW   = 3'd4;
  localparam logic [2:0] OFF_DIGI = 3'd5;
  localparam logic [2:0] OFF_TICK = 3'd6;

  logic        hit;
  logic [2:0]  idx;
  logic        wr_th, wr_tl, wr_tcon, wr_led, wr_digi;
  logic [31:0] th, tl, tick_cnt;
  logic [2:0]  tcon;
  logic [7:0]  led_r, sw_p0, sw_p1;
  logic [11:0] digi_r;
  logic [PW-1:0] pcnt;
  logic        tmr_step, tl_max, ovf;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  // Address decode: only bits [31:5] select the window, [4:2] the register
  assign hit     = (addr[31:5] == BASE[31:5]);
  assign idx     = addr[4:2];
  assign wr_th   = wr & hit & (idx == OFF_TH);
  assign wr_tl   = wr & hit & (idx == OFF_TL);
  assign wr_tcon = wr & hit & (idx == OFF_TCON);
  assign wr_led  = wr & hit & (idx == OFF_LED);
  assign wr_digi = wr & hit & (idx == OFF_DIGI);

  function automatic logic [31:0] read_mux(input logic [2:0] sel,
                                           input logic [31:0] th_v,
                                           input logic [31:0] tl_v,
                                           input logic [2:0]  tcon_v,
                                           input logic [7:0]  led_v,
                                           input logic [7:0]  sw_v,
                                           input logic [11:0] digi_v,
                                           input logic [31:0] tick_v);
    logic [31:0] v;
    v = '0;
    case (sel)
      OFF_TH:   v = th_v;
      OFF_TL:   v = tl_v;
      OFF_TCON: v = {29'd0, tcon_v};
      OFF_LED:  v = {24'd0, led_v};
      OFF_SW:   v = {24'd0, sw_v};
      OFF_DIGI: v = {20'd0, digi_v};
      OFF_TICK: v = tick_v;
      default:  v = '0;
    endcase
    return v;
  endfunction

  always_comb begin
    rdata = '0;
    if (rd && hit) begin
      rdata = read_mux(idx, th, tl, tcon, led_r, sw_p1, digi_r, tick_cnt);
    end
  end

  // Prescaler: counts only while the timer is enabled, step on wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (!tcon[0] || (pcnt == PLAST)) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  assign tmr_step = tcon[0] & (pcnt == PLAST);
  assign tl_max   = (tl == 32'hFFFF_FFFF);
  // A CPU write to TL in the same cycle suppresses the overflow event
  assign ovf      = tmr_step & tl_max & ~wr_tl;

  // Timer registers; reload reads the pre-write TH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th <= '0;
      tl <= '0;
    end else begin
      if (wr_th) begin
        th <= wdata;
      end
      if (wr_tl) begin
        tl <= wdata;
      end else if (tmr_step) begin
        tl <= tl_max ? th : tl + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcon <= '0;
    end else if (wr_tcon) begin
      tcon <= {wdata[2] | (ovf & wdata[1]), wdata[1:0]};
    end else if (ovf && tcon[1]) begin
      tcon[2] <= 1'b1;
    end
  end

  assign irqout = tcon[1] & tcon[2];

  // Board I/O registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_r  <= '0;
      digi_r <= '0;
    end else begin
      if (wr_led) begin
        led_r <= wdata[7:0];
      end
      if (wr_digi) begin
        digi_r <= wdata[11:0];
      end
    end
  end

  assign led  = led_r;
  assign digi = digi_r;

  // Switch synchroniser stage p0 -> p1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= switch;
      sw_p1 <= sw_p0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_peripheral_bus.sv
// Bench for peripheral_bus: register-map vectors, timer corner sequences on
// PRESCALE=1 and PRESCALE=4 instances, and a randomised run against a reference model.
module tb_peripheral_bus;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [4:0] A_TH = 5'h00, A_TL = 5'h04, A_TCON = 5'h08, A_LED = 5'h0C,
                         A_SW = 5'h10, A_DIGI = 5'h14, A_TICK = 5'h18, A_NONE = 5'h1C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = BASE, wdata = '0;
  logic [7:0]  switch = '0;
  logic [31:0] rdata1, rdata4;
  logic [7:0]  led1, led4;
  logic [11:0] digi1, digi4;
  logic        irq1, irq4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  peripheral_bus #(.BASE(BASE), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .switch(switch), .led(led1), .digi(digi1), .irqout(irq1));

  peripheral_bus #(.BASE(BASE), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata4), .switch(switch), .led(led4), .digi(digi4), .irqout(irq4));

  typedef struct packed {
    logic        rst;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_led;
    logic [11:0] exp_digi;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic r_, input logic rd_, input logic wr_, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] er, input logic [7:0] el,
                     input logic [11:0] ed);
    vec_t v;
    v = {r_, rd_, wr_, a, d, er, el, ed};
    tv.push_back(v);
  endtask

  // Drive at a falling edge, hold across one rising edge, return at the next falling edge
  task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    rd = r; wr = w; addr = a; wdata = d;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic wreg(input logic [4:0] off, input logic [31:0] d);
    cyc(1'b0, 1'b1, BASE + {27'd0, off}, d);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, BASE, 32'd0);
  endtask

  task automatic rreg(input logic [4:0] off, output logic [31:0] v1, output logic [31:0] v4);
    rd = 1'b1; wr = 1'b0; addr = BASE + {27'd0, off};
    #1;
    v1 = rdata1; v4 = rdata4;
    rd = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference model of the PRESCALE=1 instance
  logic [31:0] m_th, m_tl, m_tick;
  logic        m_en, m_ie, m_st;
  logic [7:0]  m_led, m_sw0, m_sw1;
  logic [11:0] m_digi;

  task automatic model_clear;
    m_th = 0; m_tl = 0; m_tick = 0; m_en = 0; m_ie = 0; m_st = 0;
    m_led = 0; m_sw0 = 0; m_sw1 = 0; m_digi = 0;
  endtask

  function automatic logic [31:0] model_read(input logic r, input logic [31:0] a);
    if (!r || a[31:5] != BASE[31:5]) return 32'd0;
    case (a[4:0] & 5'h1C)
      A_TH:    return m_th;
      A_TL:    return m_tl;
      A_TCON:  return {29'd0, m_st, m_ie, m_en};
      A_LED:   return {24'd0, m_led};
      A_SW:    return {24'd0, m_sw1};
      A_DIGI:  return {20'd0, m_digi};
      A_TICK:  return m_tick;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [7:0] sw);
    logic [4:0]  reg_off;
    logic        wsel, wraps;
    logic [31:0] next_tl;
    wsel    = w && (a[31:5] == BASE[31:5]);
    reg_off = a[4:0] & 5'h1C;
    // Timer advances once per clock while enabled; it overflows past all-ones
    wraps   = m_en && (m_tl == 32'hFFFF_FFFF) && !(wsel && reg_off == A_TL);
    next_tl = m_tl;
    if (m_en) next_tl = (m_tl == 32'hFFFF_FFFF) ? m_th : m_tl + 1;
    if (wsel && reg_off == A_TL) next_tl = d;
    if (wsel && reg_off == A_TCON) begin
      m_st = d[2] | (wraps & d[1]);
      m_ie = d[1];
      m_en = d[0];
    end else if (wraps && m_ie) begin
      m_st = 1'b1;
    end
    m_tl = next_tl;
    if (wsel && reg_off == A_TH)   m_th = d;
    if (wsel && reg_off == A_LED)  m_led = d[7:0];
    if (wsel && reg_off == A_DIGI) m_digi = d[11:0];
    m_tick = m_tick + 1;
    m_sw1 = m_sw0;
    m_sw0 = sw;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v1, v4;
    logic [31:0] a, d, er;
    logic        r, w;
    int          sel;

    // Reset-held reads of every offset
    for (int i = 0; i < 7; i++) add(1, 1, 0, BASE + 4 * i, 0, 0, 8'h00, 12'h000);
    add(0, 0, 1, BASE + A_LED,  32'h0000_00A5, 0, 8'h00, 12'h000);
    add(0, 1, 1, BASE + A_DIGI, 32'h0000_03F6, 0, 8'hA5, 12'h000);
    add(0, 1, 0, BASE + A_LED,  0, 32'h0000_00A5, 8'hA5, 12'h3F6);
    add(0, 1, 0, BASE + A_DIGI, 0, 32'h0000_03F6, 8'hA5, 12'h3F6);
    add(0, 1, 1, BASE + A_SW,   32'h0000_00FF, 0, 8'hA5, 12'h3F6);
    add(0, 1, 0, BASE + A_SW,   0, 0, 8'hA5, 12'h3F6);
    add(0, 1, 1, BASE + A_NONE, 32'hDEAD_BEEF, 0, 8'hA5, 12'h3F6);
    add(0, 1, 1, BASE + 32'h2C, 32'h0000_0011, 0, 8'hA5, 12'h3F6);
    add(0, 1, 0, BASE + A_LED + 3, 0, 32'h0000_00A5, 8'hA5, 12'h3F6);
    add(0, 0, 0, BASE + A_LED,  0, 0, 8'hA5, 12'h3F6);
    add(0, 1, 1, BASE + A_LED,  32'hFFFF_FF3C, 32'h0000_00A5, 8'hA5, 12'h3F6);
    add(0, 1, 0, BASE + A_LED,  0, 32'h0000_003C, 8'h3C, 12'h3F6);
    add(0, 0, 1, BASE + A_DIGI, 32'hFFFF_FFFF, 0, 8'h3C, 12'h3F6);
    add(0, 1, 0, BASE + A_DIGI, 0, 32'h0000_0FFF, 8'h3C, 12'hFFF);

    @(negedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      reset = tv[i].rst; rd = tv[i].rd; wr = tv[i].wr;
      addr = tv[i].addr; wdata = tv[i].wdata;
      #1;
      chk($sformatf("vec%0d rdata", i), rdata1, tv[i].exp_rdata);
      chk($sformatf("vec%0d led", i), {24'd0, led1}, {24'd0, tv[i].exp_led});
      chk($sformatf("vec%0d digi", i), {20'd0, digi1}, {20'd0, tv[i].exp_digi});
      if (tv[i].rst) chk($sformatf("vec%0d irqout", i), {31'd0, irq1}, 32'd0);
      @(negedge clk);
    end
    rd = 1'b0; wr = 1'b0;

    // Overflow and reload
    wreg(A_TH, 32'hFFFF_FFFC);
    wreg(A_TL, 32'hFFFF_FFFE);
    wreg(A_TCON, 32'd3);
    rreg(A_TL, v1, v4); chk("ovf tl start", v1, 32'hFFFF_FFFE);
    chk("ovf irq before", {31'd0, irq1}, 32'd0);
    idle(1);
    rreg(A_TL, v1, v4); chk("ovf tl max", v1, 32'hFFFF_FFFF);
    idle(1);
    rreg(A_TL, v1, v4); chk("ovf tl reload", v1, 32'hFFFF_FFFC);
    chk("ovf irq set", {31'd0, irq1}, 32'd1);
    rreg(A_TCON, v1, v4); chk("ovf tcon", v1, 32'd7);

    // Clearing status, and collisions with the overflow cycle
    wreg(A_TCON, 32'd3);
    chk("clr irq", {31'd0, irq1}, 32'd0);
    rreg(A_TCON, v1, v4); chk("clr tcon", v1, 32'd3);
    wreg(A_TL, 32'hFFFF_FFFE); idle(1); wreg(A_TCON, 32'd3);
    chk("tcon-on-ovf irq", {31'd0, irq1}, 32'd1);
    rreg(A_TCON, v1, v4); chk("tcon-on-ovf tcon", v1, 32'd7);
    rreg(A_TL, v1, v4); chk("tcon-on-ovf tl", v1, 32'hFFFF_FFFC);
    wreg(A_TCON, 32'd3); wreg(A_TL, 32'hFFFF_FFFE); idle(1); wreg(A_TL, 32'h0000_1234);
    rreg(A_TL, v1, v4); chk("tl-on-ovf tl", v1, 32'h0000_1234);
    chk("tl-on-ovf irq", {31'd0, irq1}, 32'd0);
    wreg(A_TL, 32'hFFFF_FFFE); idle(1); wreg(A_TH, 32'h0000_0010);
    rreg(A_TL, v1, v4); chk("th-on-ovf tl", v1, 32'hFFFF_FFFC);
    chk("th-on-ovf irq", {31'd0, irq1}, 32'd1);
    rreg(A_TH, v1, v4); chk("th-on-ovf th", v1, 32'h0000_0010);
    wreg(A_TCON, 32'd5);
    chk("mask irq", {31'd0, irq1}, 32'd0);
    rreg(A_TCON, v1, v4); chk("mask tcon", v1, 32'd5);

    // Prescaled timer on the PRESCALE=4 instance
    do_reset();
    wreg(A_TCON, 32'd1);
    idle(3);
    rreg(A_TL, v1, v4); chk("presc tl 3clk", v4, 32'd0);
    idle(1);
    rreg(A_TL, v1, v4); chk("presc tl 4clk", v4, 32'd1);
    idle(16);
    rreg(A_TL, v1, v4); chk("presc tl 20clk", v4, 32'd5);
    wreg(A_TCON, 32'd0);
    idle(10);
    rreg(A_TL, v1, v4); chk("presc tl frozen", v4, 32'd5);
    chk("p1 tl frozen", v1, 32'd21);

    // Switch synchroniser latency and asynchronous reset mid-count
    do_reset();
    switch = 8'h5C;
    idle(1);
    rreg(A_SW, v1, v4); chk("sw 1clk", v1, 32'd0);
    idle(1);
    rreg(A_SW, v1, v4); chk("sw 2clk", v1, 32'h0000_005C);
    wreg(A_TH, 32'd0); wreg(A_TL, 32'hFFFF_FFFF); wreg(A_TCON, 32'd3);
    idle(1);
    chk("pre-reset irq", {31'd0, irq1}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async reset irq", {31'd0, irq1}, 32'd0);
    rreg(A_TL, v1, v4);   chk("async reset tl", v1, 32'd0);
    rreg(A_TCON, v1, v4); chk("async reset tcon", v1, 32'd0);
    rreg(A_TICK, v1, v4); chk("async reset tick", v1, 32'd0);
    rreg(A_SW, v1, v4);   chk("async reset sw", v1, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Randomised traffic against the reference model
    do_reset();
    model_clear();
    for (int n = 0; n < 3000; n++) begin
      r   = 1'($urandom_range(0, 1));
      w   = ($urandom_range(0, 99) < 35);
      sel = $urandom_range(0, 7);
      a   = BASE + 4 * sel + $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) a = a ^ (32'd1 << $urandom_range(5, 31));
      d   = $urandom;
      if (sel == 1 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - $urandom_range(0, 6);
      if ($urandom_range(0, 4) == 0) switch = 8'($urandom);
      rd = r; wr = w; addr = a; wdata = d;
      #1;
      er = model_read(r, a);
      chk($sformatf("rand%0d rdata", n), rdata1, er);
      chk($sformatf("rand%0d outputs", n), {11'd0, irq1, led1, digi1},
          {11'd0, m_ie & m_st, m_led, m_digi});
      model_step(w, a, d, switch);
      @(negedge clk);
    end
    rd = 1'b0; wr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
